// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 decrypt / plaintext-check path.
//   pt_check_state_t : scan FSM states used by pt_check
//   PT_CH_LO/PT_CH_HI: printable window; the pt_check defaults and reused by the crack controller
//   in_range()       : inclusive unsigned window test on one character
package arc4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_LEN,
    RD_CHAR,
    FINISH
  } pt_check_state_t;

  localparam logic [7:0] PT_CH_LO = 8'h20;
  localparam logic [7:0] PT_CH_HI = 8'h7E;

  function automatic logic in_range(input logic [7:0] c,
                                    input logic [7:0] lo = PT_CH_LO,
                                    input logic [7:0] hi = PT_CH_HI);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage : arc4_pkg

// File: rtl/pt_check.sv
// pt_check: scans the length-prefixed plaintext in pt_mem (pt[0]=L, pt[1..L]=chars) and
// reports whether every character lies in [CH_LO, CH_HI]. Read-only on pt_mem.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   start pulse, accepted only while rdy=1
//   rdy       out  1 = idle; 0 = scan in progress
//   pt_addr   out  pt_mem read address
//   pt_rddata in   pt_mem read data, usable RD_LAT cycles after the address edge
//   valid     out  verdict of the last scan (1 = all characters in range)
//   bad_idx   out  index of the first failing character, 0 when valid=1
module pt_check
  import arc4_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  CH_LO  = PT_CH_LO,
  parameter logic [7:0]  CH_HI  = PT_CH_HI
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid,
  output logic [7:0] bad_idx
);

  // Each byte holds its address for RD_LAT+1 cycles; data is sampled when the
  // wait counter reaches RD_LAT.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT);

  pt_check_state_t state_q, state_d;
  logic [1:0]      wait_q,  wait_d;
  logic [8:0]      idx_q,   idx_d;   // 9 bits so the i==L compare is safe at L=255
  logic [7:0]      len_q,   len_d;
  logic [7:0]      addr_q,  addr_d;
  logic            fail_q,  fail_d;
  logic            valid_q, valid_d;
  logic [7:0]      bad_q,   bad_d;
  logic            rdy_q,   rdy_d;

  logic            sample;

  assign sample = (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    len_d   = len_q;
    addr_d  = addr_q;
    fail_d  = fail_q;
    valid_d = valid_q;
    bad_d   = bad_q;
    rdy_d   = rdy_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          rdy_d   = 1'b0;
          valid_d = 1'b0;
          bad_d   = '0;
          addr_d  = '0;
          wait_d  = '0;
          idx_d   = '0;
          fail_d  = 1'b0;
          state_d = RD_LEN;
        end
      end

      RD_LEN: begin
        if (sample) begin
          wait_d = '0;
          len_d  = pt_rddata;
          if (pt_rddata == 8'd0) begin
            state_d = FINISH;
          end else begin
            addr_d  = 8'd1;
            idx_d   = 9'd1;
            state_d = RD_CHAR;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      RD_CHAR: begin
        if (sample) begin
          wait_d = '0;
          if (!in_range(pt_rddata, CH_LO, CH_HI)) begin
            // idx_q is left on the failing index so FINISH can report it.
            fail_d  = 1'b1;
            state_d = FINISH;
          end else if (idx_q == {1'b0, len_q}) begin
            state_d = FINISH;
          end else begin
            idx_d  = idx_q + 9'd1;
            addr_d = idx_d[7:0];
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      FINISH: begin
        valid_d = !fail_q;
        bad_d   = fail_q ? idx_q[7:0] : '0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      fail_q  <= 1'b0;
      valid_q <= 1'b0;
      bad_q   <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy     = rdy_q;
  assign pt_addr = addr_q;
  assign valid   = valid_q;
  assign bad_idx = bad_q;

endmodule : pt_check

// File: tb/tb_pt_check.sv
// Bench for pt_check: two instances (RD_LAT=1 and RD_LAT=3) share one pt_mem image.
// A scan-level model predicts verdict, ready latency and address for each instance.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en1, en3;
  logic       rdy1, rdy3, valid1, valid3;
  logic [7:0] addr1, addr3, bad1, bad3;
  logic [7:0] rd1, p3_0, p3_1, p3_2;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;
  int maxa1   = 0;

  always #5 clk = ~clk;

  pt_check #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .pt_addr(addr1),
    .pt_rddata(rd1), .valid(valid1), .bad_idx(bad1)
  );

  pt_check #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .rdy(rdy3), .pt_addr(addr3),
    .pt_rddata(p3_2), .valid(valid3), .bad_idx(bad3)
  );

  // pt_mem: registered read, extended to a 3-deep pipe for the RD_LAT=3 instance
  always @(posedge clk) begin
    rd1  <= mem[addr1];
    p3_0 <= mem[addr3];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scan-level model ----------------
  bit m_busy  [2] = '{0, 0};
  bit m_valid [2] = '{0, 0};
  bit m_ev    [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_lat   [2] = '{0, 0};
  int m_bad   [2] = '{0, 0};
  int m_eb    [2] = '{0, 0};
  int m_last  [2] = '{0, 0};
  int m_addr  [2] = '{0, 0};

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Walk the stored string: first failing index decides verdict and latency.
  function automatic void model_scan(input int r, output int lat, output bit ev,
                                     output int eb, output int last);
    int len;
    int f;
    len = int'(mem[0]);
    f   = 0;
    for (int i = 1; i <= len; i++)
      if (f == 0 && (mem[i] < 8'h20 || mem[i] > 8'h7E)) f = i;
    if (f != 0) begin
      lat = (f + 1) * (r + 1) + 1; ev = 1'b0; eb = f; last = f;
    end else begin
      lat = (len + 1) * (r + 1) + 1; ev = 1'b1; eb = 0; last = len;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int t_lat, t_eb, t_last;
    bit t_ev;
    bit en_s;
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        m_busy[s] <= 1'b0; m_valid[s] <= 1'b0; m_bad[s] <= 0;
        m_cnt[s] <= 0; m_addr[s] <= 0; m_last[s] <= 0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        en_s = (s == 0) ? en1 : en3;
        if (m_busy[s]) begin
          m_cnt[s] <= m_cnt[s] + 1;
          if (m_cnt[s] + 1 == m_lat[s]) begin
            m_busy[s]  <= 1'b0;
            m_valid[s] <= m_ev[s];
            m_bad[s]   <= m_eb[s];
            m_addr[s]  <= m_last[s];
          end
        end else if (en_s) begin
          model_scan(lat_of(s), t_lat, t_ev, t_eb, t_last);
          m_busy[s]  <= 1'b1;
          m_cnt[s]   <= 0;
          m_lat[s]   <= t_lat;
          m_ev[s]    <= t_ev;
          m_eb[s]    <= t_eb;
          m_last[s]  <= t_last;
          m_valid[s] <= 1'b0;
          m_bad[s]   <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int ea;
    int r;
    for (int s = 0; s < 2; s++) begin
      r = lat_of(s);
      if (m_busy[s]) begin
        ea = m_cnt[s] / (r + 1);
        if (ea > m_last[s]) ea = m_last[s];
      end else begin
        ea = m_addr[s];
      end
      check($sformatf("rdy_lat%0d", r),   int'((s == 0) ? rdy1   : rdy3),   int'(!m_busy[s]));
      check($sformatf("valid_lat%0d", r), int'((s == 0) ? valid1 : valid3), int'(m_valid[s]));
      check($sformatf("bad_lat%0d", r),   int'((s == 0) ? bad1   : bad3),   m_bad[s]);
      check($sformatf("addr_lat%0d", r),  int'((s == 0) ? addr1  : addr3),  ea);
    end
    if (!rdy1 && int'(addr1) > maxa1) maxa1 = int'(addr1);
  end

  // ---------------- stimulus ----------------
  task automatic load(input int len, input logic [7:0] fill);
    mem[0] = 8'(len);
    for (int i = 1; i < 256; i++) mem[i] = fill;
  endtask

  task automatic load_hi;
    mem[0] = 8'd3; mem[1] = "H"; mem[2] = "i"; mem[3] = "!";
  endtask

  // Pulse (or hold) en on instance s and count edges from the accept edge until rdy rises.
  task automatic run(input int s, input bit hold, output int cyc);
    bit r;
    @(negedge clk);
    if (s == 0) en1 = 1'b1; else en3 = 1'b1;
    maxa1 = 0;
    @(posedge clk); #1;
    if (!hold) begin en1 = 1'b0; en3 = 1'b0; end
    cyc = 0;
    r   = 1'b0;
    while (!r && cyc < 2000) begin
      @(posedge clk); cyc++; #1;
      r = (s == 0) ? rdy1 : rdy3;
    end
    en1 = 1'b0; en3 = 1'b0;
    if (!r) check("ready_timeout", cyc, -1);
  endtask

  initial begin
    int cyc;
    logic [7:0] vec [5][3];
    int         exp_bad [5];
    int         exp_cyc [5];

    en1 = 1'b0; en3 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // en while in reset must not start a scan
    en1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; en1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", int'(rdy1), 1);
    check("reset_valid", int'(valid1), 0);
    check("reset_bad", int'(bad1), 0);
    check("reset_addr", int'(addr1), 0);

    // case 1
    load_hi();
    run(0, 1'b0, cyc);
    check("c1_cycles", cyc, 9);
    check("c1_valid", int'(valid1), 1);
    check("c1_bad", int'(bad1), 0);

    // case 2: early abort at index 2
    mem[2] = 8'h07;
    run(0, 1'b0, cyc);
    check("c2_cycles", cyc, 7);
    check("c2_valid", int'(valid1), 0);
    check("c2_bad", int'(bad1), 2);
    check("c2_maxaddr", maxa1, 2);

    // case 3: empty string
    mem[0] = 8'd0;
    run(0, 1'b0, cyc);
    check("c3_cycles", cyc, 3);
    check("c3_valid", int'(valid1), 1);

    // range boundaries: {len, c1, c2}
    vec[0] = '{8'd2, 8'h20, 8'h7E}; exp_bad[0] = 0; exp_cyc[0] = 7;
    vec[1] = '{8'd2, 8'h20, 8'h1F}; exp_bad[1] = 2; exp_cyc[1] = 7;
    vec[2] = '{8'd2, 8'h7F, 8'h20}; exp_bad[2] = 1; exp_cyc[2] = 5;
    vec[3] = '{8'd1, 8'h00, 8'h41}; exp_bad[3] = 1; exp_cyc[3] = 5;
    vec[4] = '{8'd1, 8'hFF, 8'h41}; exp_bad[4] = 1; exp_cyc[4] = 5;
    for (int v = 0; v < 5; v++) begin
      mem[0] = vec[v][0]; mem[1] = vec[v][1]; mem[2] = vec[v][2];
      run(0, 1'b0, cyc);
      check($sformatf("bnd%0d_cycles", v), cyc, exp_cyc[v]);
      check($sformatf("bnd%0d_bad", v), int'(bad1), exp_bad[v]);
      check($sformatf("bnd%0d_valid", v), int'(valid1), int'(exp_bad[v] == 0));
    end

    // case 4: maximum length
    load(255, 8'h7E);
    run(0, 1'b0, cyc);
    check("c4_cycles", cyc, 513);
    check("c4_valid", int'(valid1), 1);
    mem[255] = 8'h7F;
    run(0, 1'b0, cyc);
    check("c4f_cycles", cyc, 513);
    check("c4f_valid", int'(valid1), 0);
    check("c4f_bad", int'(bad1), 255);

    // case 5: asynchronous reset mid-scan
    load_hi();
    @(negedge clk); en1 = 1'b1;
    @(posedge clk); #1 en1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("c5_rdy", int'(rdy1), 1);
    check("c5_valid", int'(valid1), 0);
    check("c5_addr", int'(addr1), 0);
    @(negedge clk); rst_n = 1'b1;
    run(0, 1'b0, cyc);
    check("c5_cycles", cyc, 9);
    check("c5_result", int'(valid1), 1);

    // case 6: en held through the scan including FINISH -> no restart
    run(0, 1'b1, cyc);
    check("c6_cycles", cyc, 9);
    repeat (3) @(posedge clk);
    #1 check("c6_no_restart", int'(rdy1), 1);

    // RD_LAT=3 rerun of case 1
    run(1, 1'b0, cyc);
    check("c6_lat3_cycles", cyc, 17);
    check("c6_lat3_valid", int'(valid3), 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_pt_check
